// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: state encoding and helpers shared by the clock sequencing controller
package clock_ctrl_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    RUN     = 3'b000,
    PAUSE   = 3'b001,
    SET_HR  = 3'b010,
    SET_MIN = 3'b011,
    SET_SEC = 3'b100
  } state_e;
  function automatic logic is_set(state_e s);
    return s inside {SET_HR, SET_MIN, SET_SEC};
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: 2-FF synchronizer plus rising-edge detector for an asynchronous pushbutton
// Ports: clk, rst (async active-low), din (raw button), pulse (one-cycle rising-edge strobe)
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sh_q <= '0;
    else sh_q <= {sh_q[1:0], din};
  assign pulse = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: run/pause/set-time sequencer generating enables for external BCD time counters
// Ports: clk; rst (async active-low); mode_btn/start_btn/inc_btn (async pushbuttons);
//        sec_cout/min_cout/hr_cout (counter carries); sec_en/min_en/hr_en (counter enables);
//        tick (registered 1 Hz pulse); day_wrap (23:59:59 rollover pulse); mode (state code)
// Optional: CLOCK_CTRL_BLINK_EN adds output blink, toggling every TICK_DIV/2 cycles in set states
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_btn,
  input  logic               start_btn,
  input  logic               inc_btn,
  input  logic               sec_cout,
  input  logic               min_cout,
  input  logic               hr_cout,
  output logic               sec_en,
  output logic               min_en,
  output logic               hr_en,
  output logic               tick,
  output logic               day_wrap,
  output logic [STATE_W-1:0] mode
`ifdef CLOCK_CTRL_BLINK_EN
  ,
  output logic               blink
`endif
);
  localparam int CNT_W = $clog2(TICK_DIV);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d, run_on, inc_ok;
  logic mode_p, start_p, inc_p;
  btn_edge u_mode  (.clk(clk), .rst(rst), .din(mode_btn),  .pulse(mode_p));
  btn_edge u_start (.clk(clk), .rst(rst), .din(start_btn), .pulse(start_p));
  btn_edge u_inc   (.clk(clk), .rst(rst), .din(inc_btn),   .pulse(inc_p));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= PAUSE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  // The prescaler only advances while RUN is both current and next, so entry
  // starts it from 0 and any exit clears it on the same edge.
  always_comb begin
    state_d = mode_p ? ((state_q == RUN || state_q == PAUSE) ? SET_HR :
                        state_q == SET_HR ? SET_MIN : state_q == SET_MIN ? SET_SEC : RUN) :
              !start_p ? state_q : state_q == RUN ? PAUSE : state_q == PAUSE ? RUN : state_q;
    run_on = state_q == RUN && state_d == RUN;
    cnt_d  = (!run_on || cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    tick_d = run_on && cnt_q == CNT_W'(TICK_DIV - 1);
  end
  // inc is dropped whenever a higher-priority button edge lands in the same cycle.
  always_comb begin
    inc_ok   = inc_p && !mode_p && !start_p;
    sec_en   = state_q == RUN ? tick_q : state_q == SET_SEC && inc_ok;
    min_en   = state_q == RUN ? tick_q && sec_cout : state_q == SET_MIN && inc_ok;
    hr_en    = state_q == RUN ? tick_q && sec_cout && min_cout : state_q == SET_HR && inc_ok;
    day_wrap = state_q == RUN && tick_q && sec_cout && min_cout && hr_cout;
    tick     = tick_q;
    mode     = state_q;
  end
`ifdef CLOCK_CTRL_BLINK_EN
  localparam int HALF = TICK_DIV / 2;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d, set_on;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  // Half-period counter keeps running across SET_* to SET_* moves.
  always_comb begin
    set_on  = is_set(state_q) && is_set(state_d);
    bcnt_d  = (!set_on || bcnt_q == CNT_W'(HALF - 1)) ? '0 : bcnt_q + 1'b1;
    blink_d = set_on && (blink_q ^ (bcnt_q == CNT_W'(HALF - 1)));
  end
  assign blink = blink_q;
`endif
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed plus randomized bench for clock_ctrl against a behavioural model
module tb_clock_ctrl;
  localparam int TD = 4;
  logic clk, rst, mode_btn, start_btn, inc_btn, sec_cout, min_cout, hr_cout;
  logic sec_en, min_en, hr_en, tick, day_wrap;
  logic [2:0] mode;
`ifdef CLOCK_CTRL_BLINK_EN
  logic blink;
`endif
  int total = 0, passed = 0, fails = 0;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .start_btn(start_btn), .inc_btn(inc_btn),
    .sec_cout(sec_cout), .min_cout(min_cout), .hr_cout(hr_cout),
    .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en), .tick(tick), .day_wrap(day_wrap),
    .mode(mode)
`ifdef CLOCK_CTRL_BLINK_EN
    , .blink(blink)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else begin
      fails++;
      if (fails <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: state as int 0..4, button sample history, cycles spent in RUN / SET_*
  int m_st = 1, rc = 0, sc = 0;
  bit [2:0] hm = 0, hs = 0, hi = 0;
  always @(posedge clk or negedge rst) begin
    int nst;
    bit mp, sp;
    if (!rst) begin
      m_st = 1; rc = 0; sc = 0; hm = 0; hs = 0; hi = 0;
    end else begin
      mp = hm[1] && !hm[2];
      sp = hs[1] && !hs[2];
      if (mp) nst = (m_st <= 1) ? 2 : (m_st == 4) ? 0 : m_st + 1;
      else if (sp && m_st <= 1) nst = 1 - m_st;
      else nst = m_st;
      rc = (nst == 0 && m_st == 0) ? rc + 1 : 0;
      sc = (nst >= 2 && m_st >= 2) ? sc + 1 : 0;
      m_st = nst;
      hm = {hm[1:0], mode_btn};
      hs = {hs[1:0], start_btn};
      hi = {hi[1:0], inc_btn};
    end
  end

  always @(negedge clk) begin
    bit run, tk, ok;
    run = m_st == 0;
    tk  = run && rc > 0 && rc % TD == 0;
    ok  = hi[1] && !hi[2] && !(hm[1] && !hm[2]) && !(hs[1] && !hs[2]);
    chk("mode", int'(mode), m_st);
    chk("tick", int'(tick), int'(tk));
    chk("sec_en", int'(sec_en), int'(run ? tk : (m_st == 4 && ok)));
    chk("min_en", int'(min_en), int'(run ? (tk && sec_cout) : (m_st == 3 && ok)));
    chk("hr_en", int'(hr_en), int'(run ? (tk && sec_cout && min_cout) : (m_st == 2 && ok)));
    chk("day_wrap", int'(day_wrap), int'(tk && sec_cout && min_cout && hr_cout));
`ifdef CLOCK_CTRL_BLINK_EN
    chk("blink", int'(blink), int'(m_st >= 2 && ((sc / (TD / 2)) % 2 == 1)));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode(input int exp);
    step(); mode_btn = 1;
    step(); step(); mode_btn = 0;
    step();
    @(negedge clk) chk("mode_seq", int'(mode), exp);
  endtask

  task automatic press_inc();
    step(); inc_btn = 1; sec_cout = 1;
    step(); step(); inc_btn = 0;
    @(negedge clk);
    chk("inc_min_en", int'(min_en), 1);
    chk("inc_other_en", int'({sec_en, hr_en}), 0);
    step();
    @(negedge clk) chk("inc_min_en_off", int'(min_en), 0);
  endtask

  task automatic press_start_to_run();
    step(); start_btn = 1;
    step(); step(); start_btn = 0;
    @(negedge clk) chk("start_pre", int'(mode), 1);
    step();
    @(negedge clk) chk("start_run", int'(mode), 0);
  endtask

  initial begin
    rst = 1; mode_btn = 0; start_btn = 0; inc_btn = 0;
    sec_cout = 0; min_cout = 0; hr_cout = 0;
    #2 rst = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_mode", int'(mode), 1);
    chk("rst_outs", int'({sec_en, min_en, hr_en, day_wrap, tick}), 0);
    step(); rst = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk) chk("pause_no_tick", int'(tick), 0);
    end
    press_start_to_run();
    repeat (3) step();
    @(negedge clk) chk("first_tick_early", int'(tick), 0);
    step();
    @(negedge clk);
    chk("first_tick", int'(tick), 1);
    chk("sec_en_tick", int'(sec_en), 1);
    chk("min_en_nocarry", int'(min_en), 0);
    step(); sec_cout = 1; min_cout = 1; hr_cout = 1;
    @(negedge clk) chk("tick_one_cycle", int'(tick), 0);
    repeat (3) step();
    @(negedge clk) chk("all_en_wrap", int'({sec_en, min_en, hr_en, day_wrap}), 15);
    step(); sec_cout = 0; min_cout = 0; hr_cout = 0;
    @(negedge clk) chk("wrap_one_cycle", int'(day_wrap), 0);
    press_mode(2);
    press_mode(3);
    press_inc();
    press_inc();
    step(); sec_cout = 0;
    press_mode(4);
    press_mode(0);
    step(); mode_btn = 1; start_btn = 1;
    step(); step(); mode_btn = 0; start_btn = 0;
    step();
    @(negedge clk);
    chk("mode_beats_start", int'(mode), 2);
    chk("presc_cleared", int'(tick), 0);
    press_mode(3);
    press_mode(4);
    press_mode(0);
    step(); step();
    #1 rst = 0;
    #1;
    chk("async_rst_mode", int'(mode), 1);
    chk("async_rst_outs", int'({sec_en, min_en, hr_en, day_wrap, tick}), 0);
    step(); rst = 1;
    press_start_to_run();
    repeat (3) step();
    @(negedge clk) chk("restart_tick_early", int'(tick), 0);
    step();
    @(negedge clk) chk("restart_tick", int'(tick), 1);
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 4) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 2) == 0) inc_btn = ~inc_btn;
      sec_cout = 1'($urandom_range(0, 1));
      min_cout = 1'($urandom_range(0, 1));
      hr_cout  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 399) != 0);
    end
    step(); rst = 1;
    @(negedge clk);
    #1 $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
